// File: rtl/td4_ctrl_seq_pkg.sv
// Shared definitions for the TD4 sequencer: opcodes, ALU source selects,
// load-strobe bit positions and the sequencer state encoding.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_STEP,
    ST_HALT
  } state_e;

  // Opcodes 1000, 1010, 1100 and 1101 are the only undefined encodings.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      4'b1000, 4'b1010, 4'b1100, 4'b1101: legal = 1'b0;
      default:                            legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/td4_ctrl_seq_op_decode.sv
// Combinational TD4 opcode decoder: {op, carry} -> ALU source select,
// write strobes and a legality flag.
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       carry,
  output logic [1:0] sel,
  output logic [3:0] load,
  output logic       legal
);

  always_comb begin
    sel   = SEL_A;
    load  = '0;
    legal = op_is_legal(op);
    case (op)
      OP_ADD_A_IM: begin sel = SEL_A;    load[LD_A]   = 1'b1; end
      OP_ADD_B_IM: begin sel = SEL_B;    load[LD_B]   = 1'b1; end
      OP_MOV_A_IM: begin sel = SEL_ZERO; load[LD_A]   = 1'b1; end
      OP_MOV_B_IM: begin sel = SEL_ZERO; load[LD_B]   = 1'b1; end
      OP_MOV_A_B:  begin sel = SEL_B;    load[LD_A]   = 1'b1; end
      OP_MOV_B_A:  begin sel = SEL_A;    load[LD_B]   = 1'b1; end
      OP_IN_A:     begin sel = SEL_IN;   load[LD_A]   = 1'b1; end
      OP_IN_B:     begin sel = SEL_IN;   load[LD_B]   = 1'b1; end
      OP_OUT_B:    begin sel = SEL_B;    load[LD_OUT] = 1'b1; end
      OP_OUT_IM:   begin sel = SEL_ZERO; load[LD_OUT] = 1'b1; end
      OP_JMP:      begin sel = SEL_ZERO; load[LD_PC]  = 1'b1; end
      OP_JNC:      begin sel = SEL_ZERO; load[LD_PC]  = ~carry; end
      default:     begin sel = SEL_A;    load         = '0;   end
    endcase
  end

endmodule

// File: rtl/td4_ctrl_seq.sv
// TD4 fetch/decode/execute sequencer: owns PC, instruction register and carry,
// fetches over a req/ack ROM handshake and drives registered sel/load/imm.
module td4_ctrl_seq
  import td4_pkg::*;
#(
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned STEP_MODE       = 0,
  parameter int unsigned HALT_ON_ILLEGAL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_en,
  output logic                rom_req,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic                rom_ack,
  input  logic [4+DATA_W-1:0] rom_data,
  input  logic                alu_carry,
  output logic [1:0]          sel,
  output logic [3:0]          load,
  output logic [DATA_W-1:0]   imm,
  output logic [ADDR_W-1:0]   pc,
  output logic                carry,
  output logic                halted,
  output logic                illegal
);

  localparam int unsigned IW = 4 + DATA_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic                carry_q, carry_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          load_q, load_d;
  logic                illegal_q, illegal_d;

  logic [1:0]          dec_sel;
  logic [3:0]          dec_load;
  logic                dec_legal;
  logic                exec_legal;
  logic [ADDR_W+DATA_W-1:0] jump_ext;
  logic [ADDR_W-1:0]   jump_target;

  // Decode the incoming word so sel/load are registered on the ack edge;
  // JNC sees the carry value from before this instruction executes.
  td4_op_decode u_dec (
    .op    (rom_data[IW-1:DATA_W]),
    .carry (carry_q),
    .sel   (dec_sel),
    .load  (dec_load),
    .legal (dec_legal)
  );

  assign exec_legal  = op_is_legal(ir_q[IW-1:DATA_W]);
  // Zero-extends a narrow immediate or truncates a wide one to the PC width.
  assign jump_ext    = {{ADDR_W{1'b0}}, ir_q[DATA_W-1:0]};
  assign jump_target = jump_ext[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    carry_d   = carry_q;
    sel_d     = sel_q;
    load_d    = '0;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (rom_ack) begin
          ir_d    = rom_data;
          sel_d   = dec_sel;
          load_d  = dec_load;
          state_d = ST_EXEC;
          if (!dec_legal) illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        pc_d = load_q[LD_PC] ? jump_target : pc_q + ADDR_W'(1);
        if (exec_legal) carry_d = alu_carry;
        if (!exec_legal && (HALT_ON_ILLEGAL != 0)) state_d = ST_HALT;
        else if (STEP_MODE != 0)                   state_d = ST_STEP;
        else                                       state_d = ST_FETCH;
      end
      ST_STEP: begin
        if (step_en) state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      carry_q   <= 1'b0;
      sel_q     <= '0;
      load_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      carry_q   <= carry_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      illegal_q <= illegal_d;
    end
  end

  assign rom_req  = (state_q == ST_FETCH);
  assign rom_addr = pc_q;
  assign sel      = sel_q;
  assign load     = load_q;
  assign imm      = ir_q[DATA_W-1:0];
  assign pc       = pc_q;
  assign carry    = carry_q;
  assign halted   = (state_q == ST_HALT);
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_td4_ctrl_seq.sv
// Directed self-checking bench for td4_ctrl_seq: three instances cover the
// default build, a wide-immediate NOP-on-illegal build and single-step mode.
module tb_td4_ctrl_seq;

  logic clk;
  logic alu_carry;
  logic step_en;
  int   checks;
  int   failures;

  // u0: DATA_W=4, ADDR_W=4, STEP_MODE=0, HALT_ON_ILLEGAL=1
  logic       rst0_n, req0, ack0, carry0, halted0, illegal0, stray0;
  logic [3:0] addr0, load0, imm0, pc0;
  logic [7:0] data0;
  logic [1:0] sel0;
  logic [7:0] mem0 [16];
  int         cnt0, wait0;

  // u1: DATA_W=8, ADDR_W=4, HALT_ON_ILLEGAL=0
  logic        rst1_n, req1, ack1, carry1, halted1, illegal1;
  logic [3:0]  addr1, load1, pc1;
  logic [7:0]  imm1;
  logic [11:0] data1;
  logic [1:0]  sel1;
  logic [11:0] mem1 [16];
  int          cnt1, wait1;

  // u2: STEP_MODE=1
  logic       rst2_n, req2, ack2, carry2, halted2, illegal2;
  logic [3:0] addr2, load2, imm2, pc2;
  logic [7:0] data2;
  logic [1:0] sel2;
  logic [7:0] mem2 [16];
  int         cnt2, wait2;

  td4_ctrl_seq u0 (
    .clk(clk), .rst_n(rst0_n), .step_en(step_en), .rom_req(req0), .rom_addr(addr0),
    .rom_ack(ack0), .rom_data(data0), .alu_carry(alu_carry), .sel(sel0), .load(load0),
    .imm(imm0), .pc(pc0), .carry(carry0), .halted(halted0), .illegal(illegal0)
  );

  td4_ctrl_seq #(.DATA_W(8), .ADDR_W(4), .STEP_MODE(0), .HALT_ON_ILLEGAL(0)) u1 (
    .clk(clk), .rst_n(rst1_n), .step_en(step_en), .rom_req(req1), .rom_addr(addr1),
    .rom_ack(ack1), .rom_data(data1), .alu_carry(alu_carry), .sel(sel1), .load(load1),
    .imm(imm1), .pc(pc1), .carry(carry1), .halted(halted1), .illegal(illegal1)
  );

  td4_ctrl_seq #(.STEP_MODE(1)) u2 (
    .clk(clk), .rst_n(rst2_n), .step_en(step_en), .rom_req(req2), .rom_addr(addr2),
    .rom_ack(ack2), .rom_data(data2), .alu_carry(alu_carry), .sel(sel2), .load(load2),
    .imm(imm2), .pc(pc2), .carry(carry2), .halted(halted2), .illegal(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: ack after wait_n cycles of continuous request.
  assign ack0  = (req0 && (cnt0 >= wait0)) || stray0;
  assign data0 = mem0[addr0];
  assign ack1  = req1 && (cnt1 >= wait1);
  assign data1 = mem1[addr1];
  assign ack2  = req2 && (cnt2 >= wait2);
  assign data2 = mem2[addr2];

  always @(posedge clk) begin
    cnt0 <= req0 ? cnt0 + 1 : 0;
    cnt1 <= req1 ? cnt1 + 1 : 0;
    cnt2 <= req2 ? cnt2 + 1 : 0;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    wait0 = 0; wait1 = 0; wait2 = 0;
    stray0 = 1'b0; alu_carry = 1'b0; step_en = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'h30; mem1[i] = 12'h300; mem2[i] = 8'h30;
    end
    tick(); tick();

    // Reset state
    chk("rst_req", req0, 0);     chk("rst_load", load0, 0);
    chk("rst_pc", pc0, 0);       chk("rst_carry", carry0, 0);
    chk("rst_halted", halted0, 0); chk("rst_illegal", illegal0, 0);
    chk("rst_sel", sel0, 0);     chk("rst_imm", imm0, 0);

    // MOV A,3 ; ADD A,2 with zero-wait ROM
    mem0[0] = 8'h33; mem0[1] = 8'h02;
    rst0_n = 1'b1;
    tick(); chk("a_fetch_req", req0, 1); chk("a_fetch_addr", addr0, 0); chk("a_fetch_load", load0, 0);
    tick(); chk("a_mov_load", load0, 4'b0001); chk("a_mov_sel", sel0, 3);
            chk("a_mov_imm", imm0, 3); chk("a_mov_pc", pc0, 0);
    tick(); chk("a_f2_load", load0, 0); chk("a_f2_pc", pc0, 1);
    tick(); chk("a_add_load", load0, 4'b0001); chk("a_add_sel", sel0, 0); chk("a_add_imm", imm0, 2);
    tick(); chk("a_end_pc", pc0, 2);

    // ADD A,2 with carry out, JNC 7 not taken, then JNC 7 taken
    rst0_n = 1'b0;
    mem0[0] = 8'h02; mem0[1] = 8'hE7; mem0[2] = 8'hE7;
    alu_carry = 1'b1;
    tick(); chk("b_rst_pc", pc0, 0); chk("b_rst_req", req0, 0);
    rst0_n = 1'b1;
    tick();
    tick(); chk("b_add_load", load0, 4'b0001);
    tick(); chk("b_carry_set", carry0, 1);
    tick(); chk("b_jnc_nt_load", load0, 4'b0000); chk("b_jnc_sel", sel0, 3);
    alu_carry = 1'b0;
    tick(); chk("b_jnc_nt_pc", pc0, 2); chk("b_carry_clr", carry0, 0);
    tick(); chk("b_jnc_t_load", load0, 4'b1000);
    tick(); chk("b_jnc_t_pc", pc0, 7);

    // JMP F then fall-through wraps PC to 0
    rst0_n = 1'b0;
    mem0[0] = 8'hFF; mem0[15] = 8'h30;
    tick(); rst0_n = 1'b1;
    tick();
    tick(); chk("c_jmp_load", load0, 4'b1000);
    tick(); chk("c_jmp_pc", pc0, 15);
    tick();
    tick(); chk("c_wrap_pc", pc0, 0); chk("c_wrap_req", req0, 1);

    // Three wait states, then a stray ack during EXEC
    rst0_n = 1'b0;
    mem0[0] = 8'h35; mem0[1] = 8'h01;
    wait0 = 3;
    tick(); rst0_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("d_wait_req", req0, 1); chk("d_wait_addr", addr0, 0); chk("d_wait_load", load0, 0);
      tick();
    end
    chk("d_exec_load", load0, 4'b0001); chk("d_exec_imm", imm0, 5);
    stray0 = 1'b1;
    tick(); chk("d_stray_req", req0, 1); chk("d_stray_load", load0, 0); chk("d_stray_pc", pc0, 1);
    stray0 = 1'b0;
    tick(); chk("d_wait2_req", req0, 1); chk("d_wait2_load", load0, 0);
    wait0 = 0;

    // Illegal op halts; stray acks in HALT are ignored
    rst0_n = 1'b0;
    mem0[0] = 8'hA5;
    tick(); rst0_n = 1'b1;
    tick();
    tick(); chk("e_ill_load", load0, 0); chk("e_ill_flag", illegal0, 1); chk("e_ill_nohalt", halted0, 0);
    tick(); chk("e_halted", halted0, 1); chk("e_halt_req", req0, 0); chk("e_halt_pc", pc0, 1);
    stray0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("e_hold_halted", halted0, 1); chk("e_hold_req", req0, 0);
      chk("e_hold_load", load0, 0);     chk("e_hold_pc", pc0, 1);
    end
    stray0 = 1'b0;

    // Wide immediate JMP truncates; illegal op executes as NOP
    mem1[0] = 12'hFA7; mem1[7] = 12'hA00;
    alu_carry = 1'b1;
    rst1_n = 1'b1;
    tick();
    tick(); chk("f_jmp_load", load1, 4'b1000); chk("f_jmp_imm", imm1, 8'hA7);
    tick(); chk("f_jmp_pc", pc1, 7); chk("f_carry", carry1, 1);
    alu_carry = 1'b0;
    tick(); chk("f_nop_load", load1, 0); chk("f_nop_ill", illegal1, 1);
    tick(); chk("f_nop_pc", pc1, 8); chk("f_nop_carry", carry1, 1);
    chk("f_nop_halted", halted1, 0); chk("f_nop_req", req1, 1);

    // Single-step: step_en in FETCH ignored, stall until step_en, reset mid-fetch
    mem2[0] = 8'h31; mem2[1] = 8'h32;
    wait2 = 2;
    rst2_n = 1'b1;
    tick(); chk("g_fetch_req", req2, 1);
    step_en = 1'b1;
    tick(); step_en = 1'b0;
    tick();
    tick(); chk("g_exec_load", load2, 4'b0001);
    tick(); chk("g_step_req", req2, 0); chk("g_step_pc", pc2, 1); chk("g_step_halted", halted2, 0);
    tick(); chk("g_stall1_req", req2, 0);
    tick(); chk("g_stall2_req", req2, 0);
    step_en = 1'b1;
    tick(); chk("g_go_req", req2, 1); chk("g_go_addr", addr2, 1);
    step_en = 1'b0;
    tick();
    rst2_n = 1'b0;
    #1; chk("g_rst_req", req2, 0); chk("g_rst_pc", pc2, 0); chk("g_rst_load", load2, 0);
    tick(); rst2_n = 1'b1;
    tick(); chk("g_restart_req", req2, 1); chk("g_restart_addr", addr2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
